ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Receives raw PS/2 keyboard frames on ps2_clk/ps2_data.
- Strips scan-code set 2 prefixes: E0 marks an extended key, F0 marks a break, and E1 starts the Pause sequence.
- Emits one key event per make/break on key_strobe/key_pressed/key_extended/key_code.
- Sits between the PS/2 pins and the keyboard matrix block, which detects events by any change on these signals.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronized ps2_clk samples required before the filtered clock changes level.
- TIMEOUT_CYCLES, 50000: clk cycles allowed between falling edges inside a frame before the frame is abandoned.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- ps2_clk  input  1  PS/2 clock line, asynchronous.
- ps2_data  input  1  PS/2 data line, asynchronous.
- key_strobe  output  1  toggles once per decoded key event.
- key_pressed  output  1  1 = make, 0 = break.
- key_extended  output  1  event was prefixed by E0.
- key_code  output  8  scan code without prefixes.
- frame_error  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Outputs: key_strobe=0, key_pressed=0, key_extended=0, key_code=8'h00, frame_error=0.
  - Internal: RX FSM to IDLE, ext/brk flags cleared, skip counter=0, watchdog=0, filter state=1 (line idle high).
  - A frame in progress is abandoned with no error pulse.
- Input conditioning:
  - 2-FF synchronizer on both lines.
  - Filtered clock follows synchronized ps2_clk only after FILTER_LEN equal consecutive samples.
  - Falling edge of the filtered clock = 1-cycle fall strobe; data is sampled from the synchronized ps2_data in that cycle.
- RX FSM (states IDLE, DATA, PARITY, STOP), advancing only on fall strobe:
  - IDLE: data=0 -> DATA with bit_cnt=0. Data=1 -> stay in IDLE, ignored.
  - DATA: shift in LSB first, bit_cnt+1. After bit 7 -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: if stop==1 and the 8 data bits plus parity hold an odd count of 1s, pulse byte_valid next cycle. Otherwise pulse frame_error. Either way -> IDLE.
- Watchdog:
  - Counts clk cycles while not in IDLE; cleared on every fall strobe.
  - At TIMEOUT_CYCLES: frame_error pulse, FSM -> IDLE, ext/brk/skip cleared.
- Error handling:
  - Any frame_error clears ext, brk and skip.
  - No key event is ever generated from an errored frame.
- Byte decoder, evaluated on byte_valid in this priority order:
  1. skip!=0: decrement skip, drop byte.
  2. E1: skip=7, clear flags, drop.
  3. E0: ext=1.
  4. F0: brk=1.
  5. ext==0, brk==0 and byte in {00,AA,EE,FA,FC,FD,FE,FF}: drop, flags unchanged.
  6. ext==1 and byte in {12,59} (fake shift): clear flags, drop.
  7. Otherwise: key_code=byte, key_extended=ext, key_pressed=~brk, key_strobe inverted, then ext/brk cleared.
- Event timing:
  - All four event outputs update in the same cycle.
  - Latency: fall strobe of the stop bit in cycle N -> byte_valid in N+1 -> outputs in N+2.
- Typematic repeats of an identical code still toggle key_strobe, so each repeat is visible as a change.
- frame_error and byte_valid are mutually exclusive for a given frame.

Test Plan:
1. Frame 1C (bits 0,00111000,0,1), 30 us half-period, from reset.
   -> key_strobe 0->1, key_pressed=1, key_extended=0, key_code=1C.
   -> Outputs change exactly 2 cycles after the stop-bit fall strobe.
2. Send E0 75, then E0 F0 75.
   -> Two toggles: (pressed=1, ext=1, code=75), then (pressed=0, ext=1, code=75).
   -> key_strobe returns to its starting value; no toggle occurs on any prefix byte.
3. Frame 1C with parity=1.
   -> frame_error high exactly 1 cycle, no toggle.
   -> A following valid F0 1C yields pressed=0, ext=0, code=1C; prefix state is clean after the error.
4. Start bit plus 3 data bits, then ps2_clk held high.
   -> frame_error pulse TIMEOUT_CYCLES cycles after the last fall strobe, FSM back in IDLE.
   -> A following frame 29 decodes correctly.
5. Send E1 14 77 E1 F0 14 F0 77, then AA, then E0 12, then 1C.
   -> Exactly one toggle, for code 1C with ext=0, pressed=1.
6. Glitch and reset checks:
   -> ps2_clk low pulse of FILTER_LEN-2 cycles mid-idle: no bit accepted.
   -> reset low for one cycle after 5 bits of a frame: all outputs at reset values, no frame_error.
   -> The next full frame 1C decodes.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin pair plus the decoded key-event bus delivered to the keyboard matrix block.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       frame_error;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output key_strobe,
    output key_pressed,
    output key_extended,
    output key_code,
    output frame_error
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  key_strobe,
    input  key_pressed,
    input  key_extended,
    input  key_code,
    input  frame_error
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the lines, deframes bytes and strips
// scan-code set 2 prefixes into toggle-signalled key events.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  ps2_key_decoder_if.master kb
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall_stb;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [WW-1:0] wd_cnt;
  logic          byte_valid;
  logic          frame_err;

  logic          ext_flag;
  logic          brk_flag;
  logic [2:0]    skip_cnt;
  logic          key_strobe_q;
  logic          key_pressed_q;
  logic          key_extended_q;
  logic [7:0]    key_code_q;

  logic          din;
  logic          ctrl_byte_c;
  logic          fake_shift_c;

  assign din          = data_sync[1];
  assign ctrl_byte_c  = shreg inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  assign fake_shift_c = (shreg == 8'h12) || (shreg == 8'h59);

  // Synchronise both lines; the filtered clock only moves after FILTER_LEN agreeing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      fall_stb  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], kb.ps2_clk};
      data_sync <= {data_sync[0], kb.ps2_data};
      fall_stb  <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        filt_clk <= clk_sync[1];
        fall_stb <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Frame receiver with inter-edge watchdog; byte_valid and frame_err are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      wd_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_stb) begin
        wd_cnt <= WW'(1);
        case (state)
          S_IDLE: begin
            if (!din) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= din;
            state   <= S_STOP;
          end
          S_STOP: begin
            if (din && (^{shreg, par_bit})) byte_valid <= 1'b1;
            else                            frame_err  <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end else if (state == S_IDLE) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
        // Pulse lands exactly TIMEOUT_CYCLES cycles after the last fall strobe.
        frame_err <= 1'b1;
        state     <= S_IDLE;
        wd_cnt    <= '0;
      end else begin
        wd_cnt <= wd_cnt + WW'(1);
      end
    end
  end

  // Prefix stripping and key-event generation; errors flush all prefix state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ext_flag       <= 1'b0;
      brk_flag       <= 1'b0;
      skip_cnt       <= '0;
      key_strobe_q   <= 1'b0;
      key_pressed_q  <= 1'b0;
      key_extended_q <= 1'b0;
      key_code_q     <= '0;
    end else if (frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      skip_cnt <= '0;
    end else if (byte_valid) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 3'd1;
      end else if (shreg == 8'hE1) begin
        skip_cnt <= 3'd7;
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (shreg == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (shreg == 8'hF0) begin
        brk_flag <= 1'b1;
      end else if (!ext_flag && !brk_flag && ctrl_byte_c) begin
        skip_cnt <= '0;
      end else if (ext_flag && fake_shift_c) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else begin
        key_code_q     <= shreg;
        key_extended_q <= ext_flag;
        key_pressed_q  <= ~brk_flag;
        key_strobe_q   <= ~key_strobe_q;
        ext_flag       <= 1'b0;
        brk_flag       <= 1'b0;
      end
    end
  end

  assign kb.key_strobe   = key_strobe_q;
  assign kb.key_pressed  = key_pressed_q;
  assign kb.key_extended = key_extended_q;
  assign kb.key_code     = key_code_q;
  assign kb.frame_error  = frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed and random PS/2 frames against a byte-level key-event model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int unsigned FILTER_LEN     = 8;
  localparam int unsigned TIMEOUT_CYCLES = 50000;
  // Line edge driven after posedge k reaches the fall strobe in cycle k+LAT (2 sync + filter).
  localparam int unsigned LAT = 2 + FILTER_LEN;

  typedef struct {
    int unsigned at;
    bit          err;
    bit          pressed;
    bit          ext;
    logic [7:0]  code;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int          hp = 30;
  bit          chk_en = 1'b0;

  item_t       pend[$];
  bit          m_ext, m_brk;
  int          m_skip;
  bit          e_strobe, e_pressed, e_ext;
  logic [7:0]  e_code;

  int unsigned tog_cnt = 0, err_cnt = 0, last_tog_cyc = 0, last_err_cyc = 0, last_stop = 0;
  logic        prev_strobe;

  ps2_key_decoder_if kb();

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .kb    (kb)
  );

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    pend.delete();
    m_ext = 0; m_brk = 0; m_skip = 0;
    e_strobe = 0; e_pressed = 0; e_ext = 0; e_code = 8'h00;
  endfunction

  function automatic void model_error(input int unsigned at);
    item_t it;
    m_ext = 0; m_brk = 0; m_skip = 0;
    it.at = at; it.err = 1; it.pressed = 0; it.ext = 0; it.code = 8'h00;
    pend.push_back(it);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int unsigned at);
    item_t it;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (!m_ext && !m_brk && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
      m_skip = 0;
    end
    else if (m_ext && (b == 8'h12 || b == 8'h59)) begin m_ext = 0; m_brk = 0; end
    else begin
      it.at = at; it.err = 0; it.pressed = !m_brk; it.ext = m_ext; it.code = b;
      pend.push_back(it);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fall_rise(input logic d, output int unsigned k);
    kb.ps2_data = d;
    tick(hp);
    kb.ps2_clk = 1'b0;
    k = cyc;
    tick(hp);
    kb.ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    int unsigned k;
    fall_rise(1'b0, k);
    for (int i = 0; i < 8; i++) fall_rise(b[i], k);
    fall_rise((~^b) ^ bad_par, k);
    kb.ps2_data = !bad_stop;
    tick(hp);
    kb.ps2_clk = 1'b0;
    k = cyc;
    last_stop = k;
    if (bad_par || bad_stop) model_error(k + LAT + 1);
    else                     model_byte(b, k + LAT + 2);
    tick(hp);
    kb.ps2_clk  = 1'b1;
    kb.ps2_data = 1'b1;
    tick(hp);
  endtask

  // Per-cycle compare against the model's scheduled outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        item_t it;
        bit    e_err;
        e_err = 0;
        while (pend.size() != 0 && pend[0].at <= cyc) begin
          it = pend.pop_front();
          if (it.err) e_err = (it.at == cyc);
          else begin
            e_strobe = ~e_strobe; e_pressed = it.pressed; e_ext = it.ext; e_code = it.code;
          end
        end
        chk("frame_error", {31'd0, kb.frame_error}, {31'd0, e_err});
        chk("event", {kb.key_strobe, kb.key_pressed, kb.key_extended, kb.key_code},
            {e_strobe, e_pressed, e_ext, e_code});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (prev_strobe !== kb.key_strobe) begin tog_cnt++; last_tog_cyc = cyc; end
      prev_strobe = kb.key_strobe;
      if (kb.frame_error === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
    end
  end

  initial begin
    int unsigned t0, x0, k;
    logic [7:0] ctrl_pool [8];
    logic [7:0] b;
    int r;
    ctrl_pool = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    kb.ps2_clk = 1'b1;
    kb.ps2_data = 1'b1;
    reset = 1'b0;
    tick(4);
    model_reset();
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outs", {kb.key_strobe, kb.key_pressed, kb.key_extended, kb.key_code, kb.frame_error}, 12'h000);
    tick(1);

    // 1: single make code, with exact latency
    hp = 30;
    t0 = tog_cnt;
    send_byte(8'h1C);
    chk("t1_event", {kb.key_strobe, kb.key_pressed, kb.key_extended, kb.key_code}, {3'b110, 8'h1C});
    chk("t1_toggles", tog_cnt - t0, 1);
    chk("t1_latency", last_tog_cyc - last_stop, 12);

    // 2: extended make then extended break
    hp = 20;
    t0 = tog_cnt;
    send_byte(8'hE0); send_byte(8'h75);
    chk("t2_make", {kb.key_strobe, kb.key_pressed, kb.key_extended, kb.key_code}, {3'b011, 8'h75});
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("t2_toggles", tog_cnt - t0, 2);
    chk("t2_break", {kb.key_strobe, kb.key_pressed, kb.key_extended, kb.key_code}, {3'b101, 8'h75});

    // 3: parity error flushes prefix state
    t0 = tog_cnt; x0 = err_cnt;
    send_byte(8'hE0);
    send_byte(8'h1C, 1'b1, 1'b0);
    chk("t3_err_pulses", err_cnt - x0, 1);
    chk("t3_no_toggle", tog_cnt - t0, 0);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("t3_after", {kb.key_pressed, kb.key_extended, kb.key_code}, {2'b00, 8'h1C});

    // 4: truncated frame times out
    x0 = err_cnt;
    send_byte(8'hE0);
    fall_rise(1'b0, k);
    for (int i = 0; i < 3; i++) fall_rise(1'b1, k);
    model_error(k + LAT + TIMEOUT_CYCLES);
    kb.ps2_data = 1'b1;
    tick(int'(TIMEOUT_CYCLES) + int'(LAT) + 20);
    chk("t4_err_pulses", err_cnt - x0, 1);
    chk("t4_timeout_at", last_err_cyc - k, FILTER_LEN + 2 + TIMEOUT_CYCLES);
    send_byte(8'h29);
    chk("t4_after", {kb.key_pressed, kb.key_extended, kb.key_code}, {2'b10, 8'h29});

    // 5: pause sequence, control byte and fake shift all dropped
    t0 = tog_cnt;
    foreach (ctrl_pool[i]) if (i == 0) begin end
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'hAA); send_byte(8'hE0); send_byte(8'h12); send_byte(8'h1C);
    chk("t5_toggles", tog_cnt - t0, 1);
    chk("t5_event", {kb.key_pressed, kb.key_extended, kb.key_code}, {2'b10, 8'h1C});

    // 6a: short ps2_clk glitch with data low must not start a frame
    t0 = tog_cnt; x0 = err_cnt;
    kb.ps2_data = 1'b0;
    tick(4);
    kb.ps2_clk = 1'b0;
    tick(FILTER_LEN - 2);
    kb.ps2_clk = 1'b1;
    tick(20);
    kb.ps2_data = 1'b1;
    tick(20);
    send_byte(8'h33);
    chk("t6_glitch_toggles", tog_cnt - t0, 1);
    chk("t6_glitch_event", {kb.key_pressed, kb.key_extended, kb.key_code}, {2'b10, 8'h33});

    // 6b: reset mid-frame
    fall_rise(1'b0, k);
    for (int i = 0; i < 4; i++) fall_rise(1'b1, k);
    reset = 1'b0;
    tick(1);
    model_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_reset_outs", {kb.key_strobe, kb.key_pressed, kb.key_extended, kb.key_code, kb.frame_error}, 12'h000);
    kb.ps2_data = 1'b1;
    tick(100);
    chk("t6_no_err", err_cnt - x0, 0);
    send_byte(8'h1C);
    chk("t6_after_reset", {kb.key_strobe, kb.key_pressed, kb.key_extended, kb.key_code}, {3'b110, 8'h1C});

    // Random byte mix with occasional bad frames
    for (int n = 0; n < 30; n++) begin
      hp = $urandom_range(12, 20);
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h5A;
        3: b = ctrl_pool[$urandom_range(0, 7)];
        4: b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) send_byte(b, 1'b1, 1'b0);
        else                           send_byte(b, 1'b0, 1'b1);
      end else begin
        send_byte(b);
      end
    end
    tick(40);
    chk("drain", pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
